ccr_unit: RTL
=============

# ccr_unit

Condition-code register for the five-stage pipeline. It sits directly upstream of the branch unit and supplies the 4-bit flag vector that the branch unit tests for conditional jumps. It merges per-flag ALU updates, explicit carry set/clear, and the flag-consume-on-taken-jump rule, and keeps a small shadow stack so flags survive interrupts and are restored by RTI. A same-cycle bypass output lets a branch in the execute stage see flags produced by the instruction ahead of it.

## Interface
Parameters:
- SHADOW_DEPTH, 2, number of nested interrupt flag snapshots held (≥1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze all state this cycle
- alu_flags  in  4  {V,C,N,Z} from ALU (bit0 Z, bit1 N, bit2 C, bit3 V)
- alu_flags_we  in  4  per-bit write enable for alu_flags
- setc  in  1  force C=1
- clrc  in  1  force C=0
- jmp_taken  in  1  branch unit resolved a taken jump this cycle
- jmp_type  in  2  jump type of that branch (00 JZ, 01 JN, 10 JC, 11 JMP)
- int_save  in  1  push flags onto shadow stack
- rti_restore  in  1  pop flags from shadow stack into CCR
- ccr  out  4  registered flag vector
- ccr_fwd  out  4  combinational next-state flags (bypass to branch unit)
- shadow_count  out  log2(SHADOW_DEPTH+1)  entries held
- shadow_ovf  out  1  sticky: push attempted while full
- shadow_unf  out  1  sticky: pop attempted while empty

## Operation
- Next-flag computation per bit, highest priority first:
  - rti_restore with shadow_count>0: all 4 bits from top entry.
  - C only: clrc → 0; else setc → 1 (clrc wins if both).
  - alu_flags_we[i]=1 → alu_flags[i].
  - jmp_taken and jmp_type==i (i in 0..2) → bit i cleared (flag consumed). JMP (11) clears nothing.
  - otherwise hold.
- ccr_fwd = computed next value when stall=0; equals ccr when stall=1.
- int_save: pushes ccr_fwd (the value that includes same-cycle updates); ccr itself updates normally. Push when full: dropped, shadow_ovf set, stack unchanged.
- rti_restore: pops top entry into ccr, overriding every other source. Pop when empty: ccr computed from the lower-priority sources, shadow_unf set.
- int_save and rti_restore together: restore performed, save ignored, stack count decremented by 1.
- Sticky flags clear only on reset.
- Stack is LIFO, indexed by shadow_count; no wrap-around.

## Timing
- Reset (asynchronous assert, synchronous release at clk): ccr=0000, shadow_count=0, shadow entries=0, shadow_ovf=0, shadow_unf=0.
- ccr updates on the rising edge following the inputs: 1-cycle latency. ccr_fwd has zero latency (combinational from inputs and state).
- stall=1: no change to ccr, stack, count or sticky flags; all request inputs are ignored, not queued.
- Reset asserted mid-operation overrides everything immediately; no pending push or pop survives.
- No handshakes: every request is single-cycle and acted on in that cycle.

## Structure
- Shared package: flag bit index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3) and jump-type encodings (JT_JZ, JT_JN, JT_JC, JT_JMP); the branch unit uses the same constants.
- One sub-module: ccr_shadow_stack (parameterised LIFO holding push/pop, count, ovf/unf). Flag-merge logic stays in ccr_unit.

## Test plan
- Reset, then alu_flags=0101 with we=1111 → ccr=0101 next cycle; ccr_fwd=0101 in the same cycle.
- ccr=0111, jmp_taken=1, jmp_type=00 → ccr=0110. jmp_type=11 → unchanged. Same cycle alu_flags we[0]=1 with Z=1 → Z stays 1 (ALU wins).
- setc and clrc together, with alu we[2]=1 and C=1 → C=0.
- ccr=0011: int_save. Change flags to 1100. int_save. Change to 0000. rti_restore → 1100, then rti_restore → 0011, shadow_count goes 2→1→0.
- Three saves with SHADOW_DEPTH=2 → count=2, shadow_ovf=1. Pop three times → third pop leaves ccr unchanged and sets shadow_unf=1.
- stall=1 with we=1111, setc and int_save → ccr, count and ccr_fwd hold. Assert rst_n=0 mid-sequence → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ccr_unit_pkg.sv
// Shared flag-bit and jump-type definitions for the condition-code register and the branch unit.
package ccr_unit_pkg;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    typedef logic [NUM_FLAGS-1:0] flags_t;

    typedef enum logic [1:0] {
        JT_JZ  = 2'b00,
        JT_JN  = 2'b01,
        JT_JC  = 2'b10,
        JT_JMP = 2'b11
    } jmp_type_e;

    // A taken conditional jump consumes the flag it tested; JMP tests nothing.
    function automatic logic jmp_consumes(input logic [1:0] jt, input int bit_idx);
        return (jt != JT_JMP) && (int'(jt) == bit_idx);
    endfunction

endpackage

// File: rtl/ccr_unit_if.sv
// Pipeline-side request/response bundle of the condition-code register.
interface ccr_unit_if #(
    parameter int SHADOW_DEPTH = 2
);
    import ccr_unit_pkg::*;

    localparam int CNT_W = $clog2(SHADOW_DEPTH + 1);

    logic             stall;
    flags_t           alu_flags;
    flags_t           alu_flags_we;
    logic             setc;
    logic             clrc;
    logic             jmp_taken;
    logic [1:0]       jmp_type;
    logic             int_save;
    logic             rti_restore;
    flags_t           ccr;
    flags_t           ccr_fwd;
    logic [CNT_W-1:0] shadow_count;
    logic             shadow_ovf;
    logic             shadow_unf;

    modport master (
        output stall, alu_flags, alu_flags_we, setc, clrc, jmp_taken, jmp_type,
               int_save, rti_restore,
        input  ccr, ccr_fwd, shadow_count, shadow_ovf, shadow_unf
    );

    modport slave (
        input  stall, alu_flags, alu_flags_we, setc, clrc, jmp_taken, jmp_type,
               int_save, rti_restore,
        output ccr, ccr_fwd, shadow_count, shadow_ovf, shadow_unf
    );

endinterface

// File: rtl/ccr_shadow_stack.sv
// LIFO of flag snapshots for interrupt nesting, with sticky overflow/underflow indicators.
module ccr_shadow_stack #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             top_valid,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             unf
);
    logic [WIDTH-1:0] entries [DEPTH];
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    // Pop takes precedence over a simultaneous push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && !pop && !full;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= '0;
                else if (push_ok && count_reg == CNT_W'(gi))
                    entry_reg <= push_data;
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            if (pop_ok)
                count_reg <= count_reg - CNT_W'(1);
            else if (push_ok)
                count_reg <= count_reg + CNT_W'(1);
            if (pop && empty)
                unf_reg <= 1'b1;
            if (push && !pop && full)
                ovf_reg <= 1'b1;
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (count_reg == CNT_W'(i + 1))
                top_data = entries[i];
    end

    assign top_valid = !empty;
    assign count     = count_reg;
    assign ovf       = ovf_reg;
    assign unf       = unf_reg;

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register: merges ALU, carry set/clear and jump-consume updates,
// with a combinational bypass and an interrupt shadow stack.
module ccr_unit
    import ccr_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    ccr_unit_if.slave bus
);
    localparam int CNT_W = $clog2(SHADOW_DEPTH + 1);

    flags_t           ccr_reg;
    flags_t           merge_next;
    flags_t           ccr_next;
    flags_t           top_data;
    logic             top_valid;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             unf;

    // Per-bit merge, lowest priority applied first so later sources override.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            logic bit_next;
            always_comb begin
                bit_next = ccr_reg[gi];
                if (bus.jmp_taken && jmp_consumes(bus.jmp_type, gi))
                    bit_next = 1'b0;
                if (bus.alu_flags_we[gi])
                    bit_next = bus.alu_flags[gi];
                if (gi == FLAG_C) begin
                    if (bus.clrc)
                        bit_next = 1'b0;
                    else if (bus.setc)
                        bit_next = 1'b1;
                end
            end
            assign merge_next[gi] = bit_next;
        end
    endgenerate

    always_comb begin
        ccr_next = merge_next;
        if (bus.stall)
            ccr_next = ccr_reg;
        else if (bus.rti_restore && top_valid)
            ccr_next = top_data;
    end

    // A restore in the same cycle as a save wins; the save is discarded.
    assign pop  = bus.rti_restore && !bus.stall;
    assign push = bus.int_save && !bus.rti_restore && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ccr_reg <= '0;
        else
            ccr_reg <= ccr_next;
    end

    ccr_shadow_stack #(
        .DEPTH (SHADOW_DEPTH),
        .WIDTH (NUM_FLAGS),
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (ccr_next),
        .top_data  (top_data),
        .top_valid (top_valid),
        .count     (count),
        .ovf       (ovf),
        .unf       (unf)
    );

    assign bus.ccr          = ccr_reg;
    assign bus.ccr_fwd      = ccr_next;
    assign bus.shadow_count = count;
    assign bus.shadow_ovf   = ovf;
    assign bus.shadow_unf   = unf;

endmodule
